// File: rtl/slurm16_memcpy_soc.sv
// slurm16_memcpy_soc: reduced SLURM16 SoC top with the full-chip pin-out.
// A hardwired sequencer fills a source buffer in on-chip RAM, copies it
// word-by-word to a destination buffer and flags completion on GPIO/LED/debug.
// Optional build macro: SLURM16_UART_SIGNON_EN sends 'K' on UART at each DONE entry.
module slurm16_memcpy_soc #(
  parameter int CLOCK_FREQ = 10000000,
  parameter int BAUD       = 115200,
  parameter int WORDS      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] gpio_out,
  input  logic [5:0] gpio_in,
  output logic [3:0] vid_r,
  output logic [3:0] vid_g,
  output logic [3:0] vid_b,
  output logic       vid_hsync,
  output logic       vid_vsync,
  output logic       vid_blank,
  output logic       uart_tx,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       i2s_sclk,
  output logic       i2s_lrclk,
  output logic       i2s_data,
  output logic       i2s_mclk,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic       flash_sclk,
  output logic       flash_csb,
  output logic       cpu_debug_pin
);

  typedef enum logic [1:0] {S_FILL, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [6:0] LAST_IDX = 7'(WORDS - 1);
  localparam int         BIT_DIV  = CLOCK_FREQ / BAUD;

  state_t      state_q, state_d;
  logic [15:0] regfile_q [16];
  logic [15:0] ram_q [128];
  logic [15:0] rdata_q;
  logic [6:0]  fill_q;
  logic        run_q;
  logic [8:0]  i2s_cnt_q;
  logic        ram_we;
  logic [6:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        restart;
  logic        unused_ok;

  // Restart from DONE re-initialises the sequencer but keeps RAM contents.
  assign restart = (state_q == S_DONE) && gpio_in[0];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // Next-state logic: fill, then alternate read/write until the count hits zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (fill_q == LAST_IDX) state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (regfile_q[3] == 16'd1) ? S_DONE : S_READ;
      S_DONE:  if (gpio_in[0]) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    gpio_out      = regfile_q[3][3:0];
    led_r         = 1'b1;
    led_g         = 1'b0;
    led_b         = run_q;
    cpu_debug_pin = 1'b0;
    if (state_q == S_DONE) begin
      gpio_out      = 4'hF;
      led_r         = 1'b0;
      led_g         = 1'b1;
      led_b         = 1'b0;
      cpu_debug_pin = 1'b1;
    end
  end

  // Single RAM port steering: fill pattern writes, copy reads at r1, writes at r2
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = regfile_q[1][6:0];
    ram_wdata = rdata_q;
    case (state_q)
      S_FILL: begin
        ram_we    = 1'b1;
        ram_addr  = 7'd64 + fill_q;
        ram_wdata = 16'hA500 | {9'd0, fill_q};
      end
      S_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = regfile_q[2][6:0];
      end
      default: ;
    endcase
  end

  // Synchronous RAM; writes suppressed during reset so contents survive it
  always_ff @(posedge CLK) begin
    if (ram_we && !RST) ram_q[ram_addr] <= ram_wdata;
    rdata_q <= ram_q[ram_addr];
  end

  // Register file and fill index: pointers advance together, wrapping mod 128
  always_ff @(posedge CLK) begin
    if (RST || restart) begin
      for (int k = 0; k < 16; k++) regfile_q[k] <= 16'd0;
      fill_q <= 7'd0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (fill_q == LAST_IDX) begin
            fill_q       <= 7'd0;
            regfile_q[1] <= 16'd64;
            regfile_q[2] <= 16'd0;
            regfile_q[3] <= 16'(WORDS);
          end else begin
            fill_q <= fill_q + 7'd1;
          end
        end
        S_WRITE: begin
          regfile_q[4] <= rdata_q;
          regfile_q[1] <= {9'd0, regfile_q[1][6:0] + 7'd1};
          regfile_q[2] <= {9'd0, regfile_q[2][6:0] + 7'd1};
          regfile_q[3] <= regfile_q[3] - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Free-running I2S divider and run flag (keeps led_b low while in reset)
  always_ff @(posedge CLK) begin
    if (RST) begin
      i2s_cnt_q <= 9'd0;
      run_q     <= 1'b0;
    end else begin
      i2s_cnt_q <= i2s_cnt_q + 9'd1;
      run_q     <= 1'b1;
    end
  end

  assign i2s_mclk   = i2s_cnt_q[0];
  assign i2s_sclk   = i2s_cnt_q[2];
  assign i2s_lrclk  = i2s_cnt_q[8];
  assign i2s_data   = 1'b0;
  assign vid_r      = 4'd0;
  assign vid_g      = 4'd0;
  assign vid_b      = 4'd0;
  assign vid_hsync  = 1'b1;
  assign vid_vsync  = 1'b1;
  assign vid_blank  = 1'b1;
  assign flash_csb  = 1'b1;
  assign flash_sclk = 1'b0;
  assign flash_mosi = 1'b0;

`ifdef SLURM16_UART_SIGNON_EN
  logic        uart_busy_q;
  logic [9:0]  uart_sh_q;
  logic [15:0] uart_div_q;
  logic [3:0]  uart_bit_q;
  logic        done_entry;

  assign done_entry = (state_q != S_DONE) && (state_d == S_DONE);

  // 8N1 sign-on transmitter; a frame in flight is never restarted
  always_ff @(posedge CLK) begin
    if (RST) begin
      uart_busy_q <= 1'b0;
      uart_sh_q   <= 10'h3FF;
      uart_div_q  <= 16'd0;
      uart_bit_q  <= 4'd0;
    end else if (!uart_busy_q) begin
      if (done_entry) begin
        uart_busy_q <= 1'b1;
        uart_sh_q   <= {1'b1, 8'h4B, 1'b0};
        uart_div_q  <= 16'd0;
        uart_bit_q  <= 4'd0;
      end
    end else if (uart_div_q == 16'(BIT_DIV - 1)) begin
      uart_div_q <= 16'd0;
      uart_sh_q  <= {1'b1, uart_sh_q[9:1]};
      if (uart_bit_q == 4'd9) uart_busy_q <= 1'b0;
      else                    uart_bit_q  <= uart_bit_q + 4'd1;
    end else begin
      uart_div_q <= uart_div_q + 16'd1;
    end
  end

  assign uart_tx   = uart_busy_q ? uart_sh_q[0] : 1'b1;
  assign unused_ok = &{1'b0, flash_miso, gpio_in[5:1]};
`else
  assign uart_tx   = 1'b1;
  assign unused_ok = &{1'b0, flash_miso, gpio_in[5:1], BIT_DIV[0]};
`endif

endmodule

// File: tb/tb_slurm16_memcpy_soc.sv
// Testbench for slurm16_memcpy_soc: table of status checkpoints after reset,
// plus sequences for mid-copy reset, restart from DONE and idle pin levels.
module tb_slurm16_memcpy_soc;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] gpio_in = 6'd0;
  logic       flash_miso = 1'b0;
  logic [3:0] gpio_out, vid_r, vid_g, vid_b;
  logic       vid_hsync, vid_vsync, vid_blank, uart_tx;
  logic       led_r, led_g, led_b;
  logic       i2s_sclk, i2s_lrclk, i2s_data, i2s_mclk;
  logic       flash_mosi, flash_sclk, flash_csb, cpu_debug_pin;

  slurm16_memcpy_soc dut (
    .CLK(CLK), .RST(RST), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_blank(vid_blank),
    .uart_tx(uart_tx), .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data),
    .i2s_mclk(i2s_mclk), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
    .flash_sclk(flash_sclk), .flash_csb(flash_csb), .cpu_debug_pin(cpu_debug_pin)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         n;
    logic [3:0] gpio;
    logic       r, g, b, dbg;
  } vec_t;

  vec_t vecs[11];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ncyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] gpio,
                            input logic r, input logic g, input logic b, input logic dbg);
    check({name, " gpio_out"}, 32'(gpio_out), 32'(gpio));
    check({name, " led_r"}, 32'(led_r), 32'(r));
    check({name, " led_g"}, 32'(led_g), 32'(g));
    check({name, " led_b"}, 32'(led_b), 32'(b));
    check({name, " debug"}, 32'(cpu_debug_pin), 32'(dbg));
  endtask

  // One clock; idle pins and I2S dividers are checked on every sample.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    ncyc++;
    check("video rgb", 32'({vid_r, vid_g, vid_b}), 32'd0);
    check("video sync/blank", 32'({vid_hsync, vid_vsync, vid_blank}), 32'b111);
    check("flash pins", 32'({flash_csb, flash_sclk, flash_mosi}), 32'b100);
    check("i2s_data", 32'(i2s_data), 32'd0);
    check("i2s_mclk", 32'(i2s_mclk), 32'(ncyc[0]));
    check("i2s_sclk", 32'(i2s_sclk), 32'(ncyc[2]));
    check("i2s_lrclk", 32'(i2s_lrclk), 32'(ncyc[8]));
`ifndef SLURM16_UART_SIGNON_EN
    check("uart idle", 32'(uart_tx), 32'd1);
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RST = 1'b1;
    repeat (cycles) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    ncyc = 0;
  endtask

  task automatic wait_dbg(output int cyc);
    cyc = 0;
    while (cpu_debug_pin !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_ram(input string name);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s ram[%0d]", name, i), 32'(dut.ram_q[i]), 32'(16'hA500 | 16'(i)));
    check({name, " r3"}, 32'(dut.regfile_q[3]), 32'd0);
    check({name, " r4"}, 32'(dut.regfile_q[4]), 32'h0000A50F);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{0,  4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,  4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{15, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{18, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{20, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{33, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{46, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{47, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{48, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{60, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1};

    // Power-up reset, 2 cycles
    do_reset(2);
    check("reset i2s clocks", 32'({i2s_mclk, i2s_sclk, i2s_lrclk}), 32'd0);
    check("reset uart", 32'(uart_tx), 32'd1);

    for (int i = 0; i < 11; i++) begin
      while (ncyc < vecs[i].n) step();
      check_outs($sformatf("vec%0d", i), vecs[i].gpio, vecs[i].r, vecs[i].g,
                 vecs[i].b, vecs[i].dbg);
    end
    check_ram("first copy");

`ifdef SLURM16_UART_SIGNON_EN
    begin
      logic [9:0] frame;
      frame = 10'b1_01001011_0;
      for (int k = 0; k < 10; k++) begin
        while (ncyc < 48 + 86 * k + 43) step();
        check($sformatf("uart bit%0d", k), 32'(uart_tx), 32'(frame[k]));
      end
      while (ncyc < 48 + 860 + 5) step();
      check("uart after stop", 32'(uart_tx), 32'd1);
    end
`endif

    // Reset for one cycle in the middle of the copy
    do_reset(2);
    while (ncyc < 30) step();
    do_reset(1);
    check_outs("mid reset", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid reset uart", 32'(uart_tx), 32'd1);
    wait_dbg(cyc);
    check("reset-to-done latency", 32'(cyc), 32'd48);
    check_outs("second done", 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
    check_ram("second copy");

    // Only gpio_in[0] restarts from DONE
    gpio_in = 6'b111110;
    repeat (3) step();
    check("done holds", 32'(cpu_debug_pin), 32'd1);
    gpio_in = 6'b000001;
    step();
    gpio_in = 6'd0;
    check_outs("restart", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    // gpio_in[0] is ignored while copying
    repeat (10) step();
    gpio_in = 6'b000001;
    step();
    gpio_in = 6'd0;
    check("restart ignored mid-copy", 32'(cpu_debug_pin), 32'd0);
    wait_dbg(cyc);
    check("restart-to-done latency", 32'(cyc + 11), 32'd48);
    check_outs("third done", 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
    check_ram("third copy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
